// File: rtl/stack_pop_reader.sv
// stack_pop_reader
// Drains a push-down stack from its read side and streams each popped byte
// out on a valid/ready interface, flagging the final item with out_last.
// A start command pops `count` entries, or drains until the stack reports
// empty when count is zero. The block only ever pops; stk_PushPop is tied high.
//
// Ports:
//   Clk, Rst      clock (rising edge), asynchronous active-high reset
//   start, count  sequence request and pop count (0 = drain until empty)
//   busy, done    sequence in progress / one-cycle end-of-sequence pulse
//   underflow     stack ran dry before count was met; sticky until next start
//   stk_*         stack read side: PushPop, En strobe, data_o, empty
//   out_*         output stream: data, valid, ready, last
module stack_pop_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 10
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  count,
    output logic                  busy,
    output logic                  done,
    output logic                  underflow,
    output logic                  stk_PushPop,
    output logic                  stk_En,
    input  logic [DATA_WIDTH-1:0] stk_data_o,
    input  logic                  stk_empty,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_POP,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] remaining;
    logic                 drain_mode;

    // Moore-decoded outputs: the pop strobe only exists in POP, which is only
    // reached from CHECK with a non-empty stack and with no item held.
    assign stk_PushPop = 1'b1;
    assign stk_En      = (state == S_POP);
    assign done        = (state == S_DONE);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CHECK;
            S_CHECK: state_nxt = stk_empty ? S_DONE : S_POP;
            S_POP:   state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_HOLD;
            // out_last already encodes "this was the final item"
            S_HOLD:  if (out_ready) state_nxt = out_last ? S_DONE : S_CHECK;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            busy       <= 1'b0;
            underflow  <= 1'b0;
            remaining  <= '0;
            drain_mode <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        remaining  <= count;
                        drain_mode <= (count == '0);
                        busy       <= 1'b1;
                        underflow  <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (stk_empty && !drain_mode) underflow <= 1'b1;
                end
                S_WAIT: begin
                    // stk_data_o / stk_empty now show the popped byte and
                    // the post-pop fill state.
                    out_data  <= stk_data_o;
                    out_valid <= 1'b1;
                    out_last  <= drain_mode ? stk_empty
                                            : (remaining == CNT_WIDTH'(1));
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (!drain_mode && remaining != '0)
                            remaining <= remaining - CNT_WIDTH'(1);
                    end
                end
                S_DONE: busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_pop_reader.sv
// Self-checking bench for stack_pop_reader: behavioural push-down stack model,
// table of directed pop sequences, plus hand-written backpressure, busy-start
// and mid-sequence reset cases.
module tb_stack_pop_reader;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       start;
    logic [9:0] count;
    logic       busy, done, underflow, stk_PushPop, stk_En;
    logic [7:0] stk_data_o;
    logic       stk_empty;
    logic [7:0] out_data;
    logic       out_valid, out_ready, out_last;

    always #5 Clk = ~Clk;

    stack_pop_reader #(.DATA_WIDTH(8), .CNT_WIDTH(10)) dut (
        .Clk(Clk), .Rst(Rst), .start(start), .count(count),
        .busy(busy), .done(done), .underflow(underflow),
        .stk_PushPop(stk_PushPop), .stk_En(stk_En),
        .stk_data_o(stk_data_o), .stk_empty(stk_empty),
        .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last)
    );

    // Stack model: pop on the edge with En & PushPop & !empty; data_o is the
    // registered popped value, empty reflects the post-pop fill level.
    logic [7:0] mem [0:1023];
    int         sp = 0;
    logic [7:0] stk_q = 8'd0;
    logic       push_en = 1'b0;
    logic [7:0] push_val = 8'd0;

    always @(posedge Clk) begin
        if (push_en) begin
            mem[sp] <= push_val;
            sp      <= sp + 1;
        end else if (stk_En && stk_PushPop && sp > 0) begin
            stk_q <= mem[sp-1];
            sp    <= sp - 1;
        end
    end
    assign stk_data_o = stk_q;
    assign stk_empty  = (sp == 0);

    // Illegal pop strobes: while empty or while an item is being held
    int viol = 0;
    always @(posedge Clk) begin
        if (!Rst && stk_En && (stk_empty || out_valid)) viol <= viol + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        push_en  = 1'b1;
        push_val = v;
        tick();
        push_en  = 1'b0;
    endtask

    logic [7:0] got_data [8];
    logic       got_last [8];
    int         n_got, first_v, done_c;

    // Pulse start, then collect handshaken items until done (bounded).
    task automatic run_seq(input logic [9:0] c);
        count = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        count = '0;
        chk("uf_cleared_on_start", 32'(underflow), 0);
        chk("busy_after_start", 32'(busy), 1);
        n_got = 0; first_v = -1; done_c = -1;
        for (int cyc = 1; cyc < 200; cyc++) begin
            if (out_valid && out_ready) begin
                if (first_v < 0) first_v = cyc;
                if (n_got < 8) begin
                    got_data[n_got] = out_data;
                    got_last[n_got] = out_last;
                end
                n_got++;
            end
            if (done) begin
                done_c = cyc;
                break;
            end
            tick();
        end
        chk("done_seen", 32'(done_c >= 0), 1);
    endtask

    typedef struct {
        int              n_push;
        logic [4:0][7:0] push_vals;   // pushed in index order 0..n_push-1
        logic [9:0]      cnt;
        int              n_items;
        logic [4:0][7:0] exp_data;    // index 0 = first item out
        logic [4:0]      exp_last;
        logic            exp_uf;
        int              exp_sp;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{5, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 10'd3, 3,
                    {8'd0, 8'd0, 8'd3, 8'd4, 8'd5}, 5'b00100, 1'b0, 2};
        vecs[1] = '{0, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 10'd0, 2,
                    {8'd0, 8'd0, 8'd0, 8'd1, 8'd2}, 5'b00010, 1'b0, 0};
        vecs[2] = '{2, {8'd0, 8'd0, 8'd0, 8'd20, 8'd10}, 10'd4, 2,
                    {8'd0, 8'd0, 8'd0, 8'd10, 8'd20}, 5'b00000, 1'b1, 0};
        vecs[3] = '{1, {8'd0, 8'd0, 8'd0, 8'd0, 8'd7}, 10'd1, 1,
                    {8'd0, 8'd0, 8'd0, 8'd0, 8'd7}, 5'b00001, 1'b0, 0};

        Rst = 1'b1; start = 1'b0; count = '0; out_ready = 1'b1;
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_underflow", 32'(underflow), 0);
        chk("rst_stk_en", 32'(stk_En), 0);
        chk("rst_pushpop", 32'(stk_PushPop), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_out_data", 32'(out_data), 0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        tick();

        // ---------------- table-driven sequences ----------------
        for (int i = 0; i < 4; i++) begin
            for (int p = 0; p < vecs[i].n_push; p++) push(vecs[i].push_vals[p]);
            run_seq(vecs[i].cnt);
            chk($sformatf("v%0d_items", i), 32'(n_got), 32'(vecs[i].n_items));
            for (int k = 0; k < vecs[i].n_items && k < n_got; k++) begin
                chk($sformatf("v%0d_data%0d", i, k), 32'(got_data[k]), 32'(vecs[i].exp_data[k]));
                chk($sformatf("v%0d_last%0d", i, k), 32'(got_last[k]), 32'(vecs[i].exp_last[k]));
            end
            if (vecs[i].n_items > 0) chk($sformatf("v%0d_first_lat", i), 32'(first_v), 4);
            chk($sformatf("v%0d_uf_at_done", i), 32'(underflow), 32'(vecs[i].exp_uf));
            tick();
            chk($sformatf("v%0d_busy_end", i), 32'(busy), 0);
            chk($sformatf("v%0d_done_pulse", i), 32'(done), 0);
            tick(); tick();
            chk($sformatf("v%0d_uf_sticky", i), 32'(underflow), 32'(vecs[i].exp_uf));
            chk($sformatf("v%0d_stack_sp", i), 32'(sp), 32'(vecs[i].exp_sp));
        end

        // ---------------- empty drain + start while busy ----------------
        begin
            int dones = 0, dcyc = -1;
            logic v_seen = 1'b0, en_seen = 1'b0;
            count = '0; start = 1'b1;
            tick();
            for (int cyc = 1; cyc <= 12; cyc++) begin
                if (done) begin
                    dones++;
                    if (dcyc < 0) dcyc = cyc;
                end
                if (out_valid) v_seen = 1'b1;
                if (stk_En) en_seen = 1'b1;
                if (cyc == 1) begin start = 1'b1; count = 10'd5; end
                else begin start = 1'b0; count = '0; end
                tick();
            end
            chk("empty_done_count", 32'(dones), 1);
            chk("empty_done_lat", 32'(dcyc), 2);
            chk("empty_no_valid", 32'(v_seen), 0);
            chk("empty_no_en", 32'(en_seen), 0);
            chk("empty_uf", 32'(underflow), 0);
            chk("empty_busy", 32'(busy), 0);
        end

        // ---------------- backpressure ----------------
        begin
            int vcyc = -1, bad = 0;
            push(8'd30); push(8'd40);
            out_ready = 1'b0;
            count = 10'd2; start = 1'b1;
            tick();
            start = 1'b0; count = '0;
            for (int cyc = 1; cyc < 20; cyc++) begin
                if (out_valid) begin vcyc = cyc; break; end
                tick();
            end
            chk("bp_first_lat", 32'(vcyc), 4);
            chk("bp_data", 32'(out_data), 40);
            chk("bp_last", 32'(out_last), 0);
            for (int k = 0; k < 10; k++) begin
                tick();
                if (!out_valid || out_data != 8'd40 || out_last || stk_En) bad++;
            end
            chk("bp_stable", 32'(bad), 0);
            chk("bp_sp_held", 32'(sp), 1);
            out_ready = 1'b1;
            tick();
            chk("bp_handshake_clears", 32'(out_valid), 0);
            vcyc = -1;
            for (int cyc = 1; cyc < 20; cyc++) begin
                if (out_valid) begin vcyc = cyc; break; end
                tick();
            end
            chk("bp_second_seen", 32'(vcyc > 0), 1);
            chk("bp_second_data", 32'(out_data), 30);
            chk("bp_second_last", 32'(out_last), 1);
            tick();
            chk("bp_done", 32'(done), 1);
            chk("bp_uf", 32'(underflow), 0);
            tick();
        end

        // ---------------- reset while holding an item ----------------
        begin
            int vcyc = -1;
            push(8'd50); push(8'd60); push(8'd70);
            out_ready = 1'b0;
            count = 10'd3; start = 1'b1;
            tick();
            start = 1'b0; count = '0;
            for (int cyc = 1; cyc < 20; cyc++) begin
                if (out_valid) begin vcyc = cyc; break; end
                tick();
            end
            chk("rh_hold_reached", 32'(vcyc), 4);
            #2 Rst = 1'b1;
            #1;
            chk("rh_out_valid", 32'(out_valid), 0);
            chk("rh_out_data", 32'(out_data), 0);
            chk("rh_out_last", 32'(out_last), 0);
            chk("rh_busy", 32'(busy), 0);
            chk("rh_done", 32'(done), 0);
            chk("rh_stk_en", 32'(stk_En), 0);
            @(posedge Clk); #1;
            Rst = 1'b0;
            out_ready = 1'b1;
            tick();
            chk("rh_idle_busy", 32'(busy), 0);
            chk("rh_sp_after", 32'(sp), 2);
            run_seq(10'd1);
            chk("rh_items", 32'(n_got), 1);
            chk("rh_data", 32'(got_data[0]), 60);
            chk("rh_last", 32'(got_last[0]), 1);
            tick();
            chk("rh_sp_final", 32'(sp), 1);
        end

        chk("no_illegal_pop", 32'(viol), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/stack_pop_reader.md
Name: stack_pop_reader

Overview:
- Initiator that drains a PushDownStack instance from its read side.
- On a start command it pops a programmed number of entries, or drains until empty.
- Each popped byte is presented on a valid/ready output stream with a last marker.
- Sits between the stack and any downstream consumer (UART TX, checker, DMA). The block never pushes.

Parameters:
DATA_WIDTH, 8, width of stack data and output stream
CNT_WIDTH, 10, width of pop-count request and internal remaining counter (stack depth 1024)

Ports:
Clk  input  1  system clock, rising-edge
Rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a pop sequence
count  input  CNT_WIDTH  entries to pop; 0 = drain until stack empty
busy  output  1  high from start acceptance until done
done  output  1  one-cycle pulse at end of sequence
underflow  output  1  stack went empty before count satisfied; sticky until next accepted start
stk_PushPop  output  1  to stack PushPop; constant 1 (pop)
stk_En  output  1  to stack En; one-cycle pop strobe
stk_data_o  input  DATA_WIDTH  from stack data_o
stk_empty  input  1  from stack empty
out_data  output  DATA_WIDTH  popped byte
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts when out_valid & out_ready at rising Clk
out_last  output  1  qualifies final item of sequence, valid only with out_valid

Behaviour:
- Stack contract: pop executes on the rising edge where En=1, PushPop=1, empty=0. stk_data_o and stk_empty reflect the post-pop state during the following cycle.
- Reset (async, Rst=1): state=IDLE. busy, done, underflow, stk_En, out_valid, out_last = 0; out_data = 0; remaining = 0; stk_PushPop = 1. Reset mid-sequence aborts immediately; an in-flight item is lost and the stack is not restored.
- FSM states: IDLE, CHECK, POP, WAIT, HOLD, DONE. All outputs are registered or Moore-decoded; no combinational path from inputs to outputs.
- IDLE: on start=1, latch remaining=count and drain_mode=(count==0), set busy=1, clear underflow, go to CHECK.
- CHECK:
  - stk_empty=1, drain_mode → DONE.
  - stk_empty=1, counted mode → set underflow=1, go to DONE.
  - Otherwise → POP.
- POP: stk_En=1 for exactly this cycle, then WAIT.
- WAIT: at the closing edge, out_data<=stk_data_o and out_valid<=1. out_last is set as follows, then go to HOLD:
  - counted mode: out_last<=(remaining==1).
  - drain mode: out_last<=stk_empty.
- HOLD: out_data, out_valid and out_last are held stable while out_ready=0, and stk_En stays 0.
  - On the handshake edge, clear out_valid and out_last and decrement remaining (counted mode).
  - Next state is DONE if last was flagged, else CHECK.
- DONE: done=1 for one cycle, busy<=0, then IDLE.
- Latency: first out_valid is 4 cycles after the start edge (CHECK, POP, WAIT, HOLD). Peak throughput is 1 item per 4 cycles with out_ready held high.
- start while busy=1 is ignored, and count is not re-sampled.
- Underflow sequence: out_last is never asserted and done still pulses. Items already popped were delivered normally.
- remaining never wraps: decrement occurs only in counted mode with remaining≥1.
- stk_En is never asserted while stk_empty=1 or while out_valid=1.

Test Plan:
- Bench stack model preloaded by pushing 1,2,3,4,5; start count=3, out_ready=1 → out_data 5,4,3 with out_last only on 3; done pulse; underflow=0; stack holds 2 entries; first out_valid 4 cycles after start.
- Follow-up start count=0 (drain) → out_data 2,1 with out_last on 1; done; stk_empty=1; underflow=0.
- Preload 10,20; start count=4 → out_data 20,10, out_last never set, underflow=1 sticky after done; next start clears it.
- Backpressure: one item pending, out_ready=0 for 10 cycles → out_valid=1, out_data constant, stk_En=0 throughout; out_ready=1 → single handshake, sequence continues.
- Empty stack, start count=0 → done 2 cycles after start, out_valid never set, stk_En never set; a second start pulsed during busy is ignored (exactly one done pulse).
- Assert Rst while in HOLD → all outputs 0 asynchronously before next Clk edge; after release, state is IDLE and a fresh start count=1 pops the current stack top correctly.
